// File: rtl/weight_pkg.sv
// Weight RAM shared definitions: geometry, controller state encoding, range check.
// Latency: none (declarations only).
// Backpressure: none.
// Contents: DEPTH/DW/AW, state_e {IDLE, INIT, RUN}, addr_oor() range helper.
package weight_pkg;

   localparam int DEPTH = 65;   // number of weight words
   localparam int DW    = 10;   // weight width, signed two's complement
   localparam int AW    = 7;    // address width

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      INIT = 2'd1,
      RUN  = 2'd2
   } state_e;

   // True when an address lies beyond the last weight word.
   function automatic logic addr_oor(input logic [AW-1:0] addr);
      return addr >= AW'(DEPTH);
   endfunction

endpackage

// File: rtl/weight_ram_ctrl_if.sv
// Client-side bus of the weight RAM controller: inference reads and training writes.
// Latency: acks are combinational in the request cycle; read data follows one cycle later.
// Backpressure: a requester holds req/addr(/data) until its ack; one grant per cycle.
// Modports: master = requesting clients, slave = weight_ram_ctrl.
interface weight_ram_ctrl_if;
   import weight_pkg::*;

   logic          rd_req;
   logic [AW-1:0] rd_addr;
   logic          rd_ack;
   logic          rd_valid;
   logic [DW-1:0] rd_data;
   logic          wr_req;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          wr_ack;
   logic          addr_err;

   modport master (
      output rd_req, rd_addr, wr_req, wr_addr, wr_data,
      input  rd_ack, rd_valid, rd_data, wr_ack, addr_err
   );

   modport slave (
      input  rd_req, rd_addr, wr_req, wr_addr, wr_data,
      output rd_ack, rd_valid, rd_data, wr_ack, addr_err
   );

endinterface

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter with a one-bit pointer.
// Latency: combinational grant in the request cycle; pointer updates on the next edge.
// Backpressure: at most one grant per cycle; en_i=0 blocks all grants and freezes the pointer.
// Ports: Clock, Rst (async, active-low), en_i, req_i[1:0] -> gnt_o[1:0] (one-hot or zero).
module rr_arb2 (
   input  logic       Clock,
   input  logic       Rst,
   input  logic       en_i,
   input  logic [1:0] req_i,
   output logic [1:0] gnt_o
);

   // Index of the requester that won the most recent conflict. Resets to 1 so
   // requester 0 wins the first conflict.
   logic ptr_q, ptr_d;

   always_comb begin
      gnt_o = 2'b00;
      ptr_d = ptr_q;
      if (en_i) begin
         if (&req_i) begin
            gnt_o = ptr_q ? 2'b01 : 2'b10;
            ptr_d = ~ptr_q;
         end else begin
            gnt_o = req_i;
         end
      end
   end

   always_ff @(posedge Clock or negedge Rst) begin
      if (!Rst) ptr_q <= 1'b1;
      else      ptr_q <= ptr_d;
   end

endmodule

// File: rtl/weight_ram_ctrl.sv
// Weight RAM owner: random fill from the LFSR, then read/write sharing by round-robin.
// Latency: grants combinational; rd_valid/rd_data one cycle after rd_ack; fill takes DEPTH cycles.
// Backpressure: clients hold requests until acked; no grants outside RUN or while Init is high.
// Ports: Clock, Rst, Init, Rnd; bus (client reads/writes, slave modport);
//        init_done; ram_we/ram_addr/ram_d drive the RAM, ram_q is its registered read data.
module weight_ram_ctrl
   import weight_pkg::*;
(
   input  logic              Clock,
   input  logic              Rst,
   input  logic              Init,
   input  logic [DW-1:0]     Rnd,
   weight_ram_ctrl_if.slave  bus,
   output logic              init_done,
   output logic              ram_we,
   output logic [AW-1:0]     ram_addr,
   output logic [DW-1:0]     ram_d,
   input  logic [DW-1:0]     ram_q
);

   localparam logic [1:0]    S_IDLE = IDLE;
   localparam logic [1:0]    S_INIT = INIT;
   localparam logic [1:0]    S_RUN  = RUN;
   localparam logic [AW-1:0] LAST   = AW'(DEPTH - 1);

   logic [1:0]    state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d;
   logic [AW-1:0] ram_addr_q;
   logic          rd_valid_q;
   logic          rd_oor_q;
   logic [1:0]    gnt;
   logic          arb_en;

   // Init in RUN takes the cycle away from both clients.
   assign arb_en = (state_q == S_RUN) && !Init;

   // Requester 0 = read, 1 = write.
   rr_arb2 u_arb (
      .Clock (Clock),
      .Rst   (Rst),
      .en_i  (arb_en),
      .req_i ({bus.wr_req, bus.rd_req}),
      .gnt_o (gnt)
   );

   assign bus.rd_ack   = gnt[0];
   assign bus.wr_ack   = gnt[1];
   assign bus.addr_err = (gnt[0] && addr_oor(bus.rd_addr)) ||
                         (gnt[1] && addr_oor(bus.wr_addr));
   assign init_done    = (state_q == S_RUN);
   assign bus.rd_valid = rd_valid_q;
   // An out-of-range read is acked but returns zero instead of RAM contents.
   assign bus.rd_data  = (rd_valid_q && !rd_oor_q) ? ram_q : '0;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: if (Init) begin
            state_d = S_INIT;
            cnt_d   = '0;
         end
         S_INIT: if (cnt_q == LAST) begin
            state_d = S_RUN;
            cnt_d   = '0;
         end else begin
            cnt_d   = cnt_q + 1'b1;
         end
         S_RUN: if (Init) begin
            state_d = S_INIT;
            cnt_d   = '0;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // RAM port mux. Without a grant in RUN the address holds its last value.
   always_comb begin
      ram_we   = 1'b0;
      ram_addr = ram_addr_q;
      ram_d    = '0;
      case (state_q)
         S_IDLE: ram_addr = '0;
         S_INIT: begin
            ram_we   = 1'b1;
            ram_addr = cnt_q;
            ram_d    = Rnd;
         end
         S_RUN: begin
            if (gnt[1]) begin
               ram_we   = !addr_oor(bus.wr_addr);
               ram_addr = bus.wr_addr;
               ram_d    = bus.wr_data;
            end else if (gnt[0]) begin
               ram_addr = bus.rd_addr;
            end
         end
         default: ram_addr = '0;
      endcase
   end

   always_ff @(posedge Clock or negedge Rst) begin
      if (!Rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         ram_addr_q <= '0;
         rd_valid_q <= 1'b0;
         rd_oor_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ram_addr_q <= ram_addr;
         rd_valid_q <= gnt[0];
         rd_oor_q   <= gnt[0] && addr_oor(bus.rd_addr);
      end
   end

endmodule

// File: tb/tb_weight_ram_ctrl.sv
// Bench for weight_ram_ctrl: directed steps plus a randomized read/write phase
// checked against an array model of the weight memory and the arbitration rules.
// A behavioural single-port RAM with registered read data sits on the RAM port.
module tb_weight_ram_ctrl;
   import weight_pkg::*;

   logic          Clock = 1'b0;
   logic          Rst;
   logic          Init;
   logic [DW-1:0] Rnd;
   logic          init_done;
   logic          ram_we;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_d;
   logic [DW-1:0] ram_q;

   int total = 0;
   int bad   = 0;

   weight_ram_ctrl_if bus ();

   weight_ram_ctrl dut (
      .Clock     (Clock),
      .Rst       (Rst),
      .Init      (Init),
      .Rnd       (Rnd),
      .bus       (bus),
      .init_done (init_done),
      .ram_we    (ram_we),
      .ram_addr  (ram_addr),
      .ram_d     (ram_d),
      .ram_q     (ram_q)
   );

   always #5 Clock = ~Clock;

   // RAM: full 7-bit address space so a stray out-of-range write is observable.
   logic [DW-1:0] mem [0:127];
   always @(posedge Clock) begin
      if (ram_we) mem[ram_addr] <= ram_d;
      ram_q <= mem[ram_addr];
   end

   // Reference contents of the DEPTH valid words.
   logic [DW-1:0] mem_ref [0:DEPTH-1];
   logic          last_w;   // write won the most recent conflict

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic          rq, wq, eg_r, eg_w, exp_v, exp_v_n;
      logic [AW-1:0] ra, wa;
      logic [DW-1:0] wd, exp_d, exp_d_n;

      // ---- reset with requests driven ----
      Rst = 1'b0; Init = 1'b0; Rnd = '0;
      bus.rd_req = 1'b1; bus.rd_addr = 7'd4;
      bus.wr_req = 1'b1; bus.wr_addr = 7'd9; bus.wr_data = 10'h0AA;
      #12;
      chk("rst_rd_ack",    bus.rd_ack,    0);
      chk("rst_wr_ack",    bus.wr_ack,    0);
      chk("rst_addr_err",  bus.addr_err,  0);
      chk("rst_rd_valid",  bus.rd_valid,  0);
      chk("rst_rd_data",   bus.rd_data,   0);
      chk("rst_init_done", init_done,     0);
      chk("rst_ram_we",    ram_we,        0);
      chk("rst_ram_addr",  ram_addr,      0);

      // ---- release without Init: stays idle ----
      tick();
      Rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("idle_rd_ack",    bus.rd_ack, 0);
         chk("idle_wr_ack",    bus.wr_ack, 0);
         chk("idle_ram_we",    ram_we,     0);
         chk("idle_ram_addr",  ram_addr,   0);
         chk("idle_init_done", init_done,  0);
         tick();
      end

      // ---- initial fill, Rnd = k in fill cycle k ----
      bus.rd_req = 1'b0; bus.wr_req = 1'b0;
      Init = 1'b1;
      #1;
      chk("init_cycle_we", ram_we, 0);
      tick();
      Init = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
         Rnd  = DW'(k);
         Init = (k == 10);   // must be ignored mid-fill
         #1;
         chk("fill_we",        ram_we,    1);
         chk("fill_addr",      ram_addr,  k);
         chk("fill_d",         ram_d,     k);
         chk("fill_init_done", init_done, 0);
         mem_ref[k] = DW'(k);
         tick();
      end
      Init = 1'b0;
      #1;
      chk("init_done_66", init_done, 1);
      for (int k = 0; k < DEPTH; k++) chk("fill_mem", mem[k], k);
      last_w = 1'b1;

      // ---- write then read back the next cycle ----
      bus.wr_req = 1'b1; bus.wr_addr = 7'd12; bus.wr_data = 10'h1F3;
      #1;
      chk("wr_ack",      bus.wr_ack,   1);
      chk("wr_rd_ack",   bus.rd_ack,   0);
      chk("wr_we",       ram_we,       1);
      chk("wr_addr",     ram_addr,     12);
      chk("wr_d",        ram_d,        10'h1F3);
      chk("wr_addr_err", bus.addr_err, 0);
      mem_ref[12] = 10'h1F3;
      tick();
      bus.wr_req = 1'b0;
      bus.rd_req = 1'b1; bus.rd_addr = 7'd12;
      #1;
      chk("rd_ack",  bus.rd_ack, 1);
      chk("rd_we",   ram_we,     0);
      chk("rd_addr", ram_addr,   12);
      tick();
      bus.rd_req = 1'b0;
      #1;
      chk("rd_valid",      bus.rd_valid, 1);
      chk("rd_data",       bus.rd_data,  10'h1F3);
      chk("rd_ack_once",   bus.rd_ack,   0);
      chk("idle_addr_hold", ram_addr,    12);
      tick();
      #1;
      chk("rd_valid_pulse", bus.rd_valid, 0);

      // ---- contention: R, W, R, W ----
      bus.rd_req = 1'b1; bus.rd_addr = 7'd3;
      bus.wr_req = 1'b1; bus.wr_addr = 7'd5; bus.wr_data = 10'h2AA;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("cont_rd_ack", bus.rd_ack, (i % 2 == 0));
         chk("cont_wr_ack", bus.wr_ack, (i % 2 == 1));
         if (i > 0) chk("cont_rd_valid", bus.rd_valid, (i % 2 == 1));
         tick();
      end
      mem_ref[5] = 10'h2AA;
      last_w = 1'b1;
      bus.rd_req = 1'b0; bus.wr_req = 1'b0;
      tick();

      // ---- out-of-range write and read ----
      bus.wr_req = 1'b1; bus.wr_addr = 7'd70; bus.wr_data = 10'h155;
      #1;
      chk("oor_wr_ack",   bus.wr_ack,   1);
      chk("oor_wr_err",   bus.addr_err, 1);
      chk("oor_wr_we",    ram_we,       0);
      tick();
      bus.wr_req = 1'b0;
      #1;
      chk("oor_err_pulse", bus.addr_err, 0);
      chk("oor_no_write",  (mem[70] === 10'h155), 0);
      bus.rd_req = 1'b1; bus.rd_addr = 7'd70;
      #1;
      chk("oor_rd_ack", bus.rd_ack,   1);
      chk("oor_rd_err", bus.addr_err, 1);
      tick();
      bus.rd_req = 1'b0;
      #1;
      chk("oor_rd_valid", bus.rd_valid, 1);
      chk("oor_rd_data",  bus.rd_data,  0);
      tick();

      // ---- randomized traffic against the model ----
      rq = 1'b0; wq = 1'b0; ra = '0; wa = '0; wd = '0;
      exp_v = 1'b0; exp_d = '0;
      for (int c = 0; c < 400; c++) begin
         if (!rq && $urandom_range(0, 2) != 0) begin
            rq = 1'b1; ra = AW'($urandom_range(0, 72));
         end
         if (!wq && $urandom_range(0, 2) != 0) begin
            wq = 1'b1; wa = AW'($urandom_range(0, 72)); wd = DW'($urandom);
         end
         bus.rd_req = rq; bus.rd_addr = ra;
         bus.wr_req = wq; bus.wr_addr = wa; bus.wr_data = wd;
         // Alternate on conflict, otherwise serve whoever asks.
         eg_r = rq && (!wq || last_w);
         eg_w = wq && (!rq || !last_w);
         if (rq && wq) last_w = eg_w;
         #1;
         chk("rnd_rd_ack",   bus.rd_ack,   eg_r);
         chk("rnd_wr_ack",   bus.wr_ack,   eg_w);
         chk("rnd_addr_err", bus.addr_err, (eg_r && ra >= DEPTH) || (eg_w && wa >= DEPTH));
         chk("rnd_ram_we",   ram_we,       eg_w && wa < DEPTH);
         chk("rnd_rd_valid", bus.rd_valid, exp_v);
         if (exp_v) chk("rnd_rd_data", bus.rd_data, exp_d);
         exp_v_n = eg_r;
         exp_d_n = (eg_r && ra < DEPTH) ? mem_ref[ra] : '0;
         if (eg_w && wa < DEPTH) mem_ref[wa] = wd;
         if (eg_r) rq = 1'b0;
         if (eg_w) wq = 1'b0;
         tick();
         exp_v = exp_v_n; exp_d = exp_d_n;
      end
      bus.rd_req = 1'b0; bus.wr_req = 1'b0;
      #1;
      chk("rnd_tail_valid", bus.rd_valid, exp_v);
      if (exp_v) chk("rnd_tail_data", bus.rd_data, exp_d);
      tick();

      // ---- Init in RUN with a write pending ----
      bus.wr_req = 1'b1; bus.wr_addr = 7'd20; bus.wr_data = 10'h0AB;
      Init = 1'b1;
      #1;
      chk("reinit_wr_ack", bus.wr_ack, 0);
      chk("reinit_rd_ack", bus.rd_ack, 0);
      chk("reinit_we",     ram_we,     0);
      tick();
      Init = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
         Rnd = DW'($urandom);
         #1;
         chk("refill_we",     ram_we,     1);
         chk("refill_addr",   ram_addr,   k);
         chk("refill_wr_ack", bus.wr_ack, 0);
         mem_ref[k] = Rnd;
         tick();
      end
      #1;
      chk("refill_done",   init_done,  1);
      chk("refill_wr_ack", bus.wr_ack, 1);
      chk("refill_wr_we",  ram_we,     1);
      chk("refill_wr_adr", ram_addr,   20);
      mem_ref[20] = 10'h0AB;
      tick();
      bus.wr_req = 1'b0;

      // ---- back-to-back read sweep of all words ----
      bus.rd_req = 1'b1;
      for (int k = 0; k < DEPTH; k++) begin
         bus.rd_addr = AW'(k);
         #1;
         chk("sweep_rd_ack", bus.rd_ack, 1);
         if (k > 0) begin
            chk("sweep_valid", bus.rd_valid, 1);
            chk("sweep_data",  bus.rd_data,  mem_ref[k-1]);
         end
         tick();
      end
      bus.rd_req = 1'b0;
      #1;
      chk("sweep_last", bus.rd_data, mem_ref[DEPTH-1]);
      tick();

      // ---- reset in fill cycle 30 ----
      Init = 1'b1;
      tick();
      Init = 1'b0;
      for (int k = 0; k < 30; k++) tick();
      #1;
      chk("midfill_addr", ram_addr, 30);
      Rst = 1'b0;
      #1;
      chk("midrst_init_done", init_done,    0);
      chk("midrst_we",        ram_we,       0);
      chk("midrst_addr",      ram_addr,     0);
      chk("midrst_valid",     bus.rd_valid, 0);
      bus.wr_req = 1'b1; bus.wr_addr = 7'd7; bus.wr_data = 10'h011;
      tick();
      tick();
      Rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("postrst_wr_ack",    bus.wr_ack, 0);
         chk("postrst_we",        ram_we,     0);
         chk("postrst_init_done", init_done,  0);
         tick();
      end
      bus.wr_req = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
